// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word memory responder (IDLE/BUSY/RESP); mem_resp arrives LATENCY edges after the request sample.
// Optional checker: define MEM_RESPONDER_PROTOCOL_CHECK_EN to drive the sticky proto_err flag.
module mem_responder #(
    parameter int LATENCY   = 4,
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    output logic        mem_resp,
    output logic [15:0] mem_rdata,
    output logic        proto_err
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t state, state_next;
    logic [3:0] cnt, cnt_next;
    logic [15:0] addr_q, wdata_q, addr_c, wdata_c;
    logic [1:0] be_q, be_c;
    logic wr_q, wr_c, held, latch, commit;
    logic [ADDR_BITS-1:0] idx;
    logic [15:0] mem [2**ADDR_BITS];
    logic unused_addr;
    assign unused_addr = ^{mem_address, addr_q};
    assign held = wr_q ? mem_write : mem_read;
    // Single-cycle latency skips BUSY, so the commit then uses the live inputs.
    assign addr_c  = state == IDLE ? mem_address : addr_q;
    assign wdata_c = state == IDLE ? mem_wdata : wdata_q;
    assign be_c    = state == IDLE ? mem_byte_enable : be_q;
    assign wr_c    = state == IDLE ? mem_write : wr_q;
    assign idx     = addr_c[ADDR_BITS:1];
    assign mem_resp = state == RESP;
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        latch      = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: if (mem_read || mem_write) begin
                latch      = 1'b1;
                cnt_next   = 4'(LATENCY - 1);
                state_next = LATENCY == 1 ? RESP : BUSY;
                commit     = LATENCY == 1;
            end
            BUSY: if (!held) begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end else begin
                cnt_next   = cnt - 4'd1;
                state_next = cnt == 4'd1 ? RESP : BUSY;
                commit     = cnt == 4'd1;
            end
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            addr_q    <= 16'h0;
            wdata_q   <= 16'h0;
            be_q      <= 2'b00;
            wr_q      <= 1'b0;
            mem_rdata <= 16'h0;
            for (int i = 0; i < 2**ADDR_BITS; i++) mem[i] <= 16'h0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (latch) begin
                addr_q  <= mem_address;
                wdata_q <= mem_wdata;
                be_q    <= mem_byte_enable;
                wr_q    <= mem_write;
            end
            if (commit && wr_c && be_c[0]) mem[idx][7:0] <= wdata_c[7:0];
            if (commit && wr_c && be_c[1]) mem[idx][15:8] <= wdata_c[15:8];
            if (commit && !wr_c) mem_rdata <= mem[idx];
        end
    end
`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
    logic err_event;
    assign err_event = (mem_read && mem_write) || (state == BUSY && (!held ||
        mem_address != addr_q || mem_wdata != wdata_q || mem_byte_enable != be_q));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) proto_err <= 1'b0;
        else proto_err <= proto_err | err_event;
    end
`else
    assign proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench for mem_responder against an array-based memory model.
module tb_mem_responder;
    localparam int LAT = 4;
`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n, rd, wr, rd1;
    logic [1:0] be;
    logic [15:0] addr, wdata, rdata, rdata1, last_rd;
    logic resp, perr, resp1, perr1;
    logic [15:0] model [256];
    bit exp_err;
    int n_cmp = 0, n_err = 0;

    mem_responder #(.LATENCY(LAT), .ADDR_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(rd), .mem_write(wr),
        .mem_byte_enable(be), .mem_address(addr), .mem_wdata(wdata),
        .mem_resp(resp), .mem_rdata(rdata), .proto_err(perr));

    mem_responder #(.LATENCY(1), .ADDR_BITS(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd1), .mem_write(1'b0),
        .mem_byte_enable(2'b11), .mem_address(16'h0002), .mem_wdata(16'h0000),
        .mem_resp(resp1), .mem_rdata(rdata1), .proto_err(perr1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rd = 1'b0; wr = 1'b0; rd1 = 1'b0;
        for (int i = 0; i < 256; i++) model[i] = 16'h0;
        exp_err = 1'b0;
        last_rd = 16'h0;
        repeat (2) @(negedge clk);
        check("rst_resp", resp, 0);
        check("rst_rdata", rdata, 16'h0);
        check("rst_err", perr, 0);
        rst_n = 1'b1;
    endtask

    task automatic txn(input bit w, input bit r, input logic [15:0] a, input logic [15:0] d, input logic [1:0] b);
        int n;
        logic [7:0] i;
        @(negedge clk);
        wr = w; rd = r; addr = a; wdata = d; be = b;
        if (w && r) exp_err = exp_err | CHK;
        i = a[8:1];
        if (w && b[0]) model[i][7:0] = d[7:0];
        if (w && b[1]) model[i][15:8] = d[15:8];
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp && n < 40);
        check("latency", n, LAT);
        if (w) check("rdata_hold", rdata, last_rd);
        else begin
            last_rd = model[i];
            check("rdata", rdata, model[i]);
        end
        wr = 1'b0; rd = 1'b0;
        @(negedge clk);
        check("single_pulse", resp, 0);
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0; rd = 1'b0; wr = 1'b0; rd1 = 1'b0;
        be = 2'b00; addr = 16'h0; wdata = 16'h0;
        do_reset();
        txn(1, 0, 16'h0010, 16'hBEEF, 2'b11);
        txn(0, 1, 16'h0010, 16'h0000, 2'b00);
        check("beef", rdata, 16'hBEEF);
        txn(1, 0, 16'h0020, 16'h1234, 2'b11);
        txn(1, 0, 16'h0020, 16'hAB00, 2'b10);
        txn(0, 1, 16'h0020, 16'h0000, 2'b00);
        check("upper_lane", rdata, 16'hAB34);
        txn(1, 0, 16'h0020, 16'h00CD, 2'b01);
        txn(0, 1, 16'h0020, 16'h0000, 2'b00);
        check("lower_lane", rdata, 16'hABCD);
        txn(1, 0, 16'h0021, 16'hFFFF, 2'b00);
        txn(0, 1, 16'h0020, 16'h0000, 2'b00);
        check("be_none", rdata, 16'hABCD);
        txn(1, 1, 16'h0200, 16'h7777, 2'b11);
        txn(0, 1, 16'h0000, 16'h0000, 2'b00);
        check("rw_alias", rdata, 16'h7777);
        check("rw_err", perr, CHK);
        for (int k = 0; k < 40; k++) begin
            int op;
            op = $urandom_range(0, 9);
            txn(op < 4 || op == 9, op >= 4, 16'($urandom), 16'($urandom), 2'($urandom));
        end
        check("err_after_rand", perr, exp_err);
        do_reset();
        @(negedge clk);
        rd = 1'b1; addr = 16'h0010;
        repeat (2) @(negedge clk);
        rd = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            pulses += resp;
        end
        exp_err = exp_err | CHK;
        check("abort_resp", pulses, 0);
        check("abort_err", perr, exp_err);
        do_reset();
        check("err_cleared", perr, 0);
        @(negedge clk);
        wr = 1'b1; addr = 16'h0040; wdata = 16'h5555; be = 2'b11;
        repeat (2) @(negedge clk);
        rst_n = 1'b0; wr = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            pulses += resp;
        end
        check("rst_abort_resp", pulses, 0);
        rst_n = 1'b1;
        txn(0, 1, 16'h0040, 16'h0000, 2'b00);
        check("rst_abort_data", rdata, 16'h0000);
        @(negedge clk);
        rd1 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("lat1_cadence", resp1, k % 2);
            if (resp1) check("lat1_rdata", rdata1, 16'h0000);
        end
        rd1 = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
